// File: rtl/mem_burst_ctrl_pkg.sv
// mem_burst_ctrl_pkg: FSM state type, default widths and skid depth
// shared by the burst controller and its read skid FIFO.
package mem_burst_ctrl_pkg;

    localparam int unsigned MBC_DEFAULT_A = 8;
    localparam int unsigned MBC_DEFAULT_D = 8;
    localparam int unsigned SKID_DEPTH    = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_VFY   = 3'd4
    } state_e;

endpackage

// File: rtl/mem_burst_ctrl_rd_skid_fifo.sv
// rd_skid_fifo: 2-entry FIFO that absorbs RAM read data while the
// consumer stalls. Caller guarantees no push when full, no pop when empty.
module rd_skid_fifo
    import mem_burst_ctrl_pkg::*;
#(
    parameter int unsigned D = MBC_DEFAULT_D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] din,
    output logic [D-1:0] dout,
    output logic [1:0]   count
);

    logic [D-1:0] slot_q [SKID_DEPTH];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    // Storage, pointers and occupancy update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                slot_q[wr_ptr_q] <= din;
            end
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            count_q  <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign dout  = slot_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst read/write initiator for a single-port sync RAM
// with registered read address. Optional write-verify pass is enabled by
// defining MEM_BURST_VERIFY_EN.
module mem_burst_ctrl
    import mem_burst_ctrl_pkg::*;
#(
    parameter int unsigned A = MBC_DEFAULT_A,
    parameter int unsigned D = MBC_DEFAULT_D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_we,
    input  logic [A-1:0] cmd_addr,
    input  logic [A-1:0] cmd_len,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [D-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [D-1:0] rd_data,
    output logic         busy,
    output logic         done,
    output logic         verify_err,
    output logic         mem_ce,
    output logic         mem_we,
    output logic [A-1:0] mem_addr,
    output logic [D-1:0] mem_data,
    input  logic [D-1:0] mem_q
);

    state_e       state_q, state_d;
    logic [A-1:0] start_q, start_d;
    logic [A-1:0] len_q, len_d;
    logic [A-1:0] beat_q, beat_d;
    logic         inflight_q;
    logic [A-1:0] cur_addr;
    logic         last_beat;
    logic         issue;
    logic         can_issue;
    logic         rd_pop;
    logic         fifo_push;
    logic [1:0]   fifo_count;
    logic [2:0]   occupancy;

    assign cur_addr  = start_q + beat_q;
    assign last_beat = (beat_q == len_q);
    assign rd_valid  = (fifo_count != 2'd0);
    assign rd_pop    = rd_valid && rd_ready;
    // A beat popped this cycle frees its slot at the same edge the new read lands
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, rd_pop};
    assign can_issue = (occupancy < 3'd2);
    assign busy      = (state_q != ST_IDLE);

`ifdef MEM_BURST_VERIFY_EN
    logic [D-1:0] acc_q, acc_d;
    logic         vissued_q, vissued_d;
    logic         verr_q, verr_d;

    assign fifo_push  = inflight_q && (state_q != ST_VFY);
    assign verify_err = verr_q;

    // Verify accumulator, issue-complete flag and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            vissued_q <= 1'b0;
            verr_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            vissued_q <= vissued_d;
            verr_q    <= verr_d;
        end
    end
`else
    assign fifo_push  = inflight_q;
    assign verify_err = 1'b0;
`endif

    rd_skid_fifo #(.D(D)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (rd_pop),
        .din   (mem_q),
        .dout  (rd_data),
        .count (fifo_count)
    );

    // State register and burst bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            start_q    <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            inflight_q <= issue;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        len_d   = len_q;
        beat_d  = beat_q;
`ifdef MEM_BURST_VERIFY_EN
        acc_d     = acc_q;
        vissued_d = vissued_q;
        verr_d    = verr_q;
        if (inflight_q && (state_q == ST_VFY)) begin
            acc_d = acc_q ^ mem_q;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    start_d = cmd_addr;
                    len_d   = cmd_len;
                    beat_d  = '0;
                    state_d = cmd_we ? ST_WR : ST_RD;
`ifdef MEM_BURST_VERIFY_EN
                    acc_d     = '0;
                    vissued_d = 1'b0;
                    verr_d    = 1'b0;
`endif
                end
            end
            ST_WR: begin
                if (wr_valid) begin
                    beat_d = beat_q + A'(1);
`ifdef MEM_BURST_VERIFY_EN
                    acc_d = acc_q ^ wr_data;
`endif
                    if (last_beat) begin
`ifdef MEM_BURST_VERIFY_EN
                        state_d = ST_VFY;
                        beat_d  = '0;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
            ST_RD: begin
                if (issue) begin
                    beat_d = beat_q + A'(1);
                    if (last_beat) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && (fifo_count == 2'd0)) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef MEM_BURST_VERIFY_EN
            ST_VFY: begin
                if (issue) begin
                    beat_d = beat_q + A'(1);
                    if (last_beat) begin
                        vissued_d = 1'b1;
                    end
                end
                // Written and read-back XOR cancel to zero when the range matches
                if (vissued_q && !inflight_q) begin
                    state_d = ST_IDLE;
                    if (acc_q != '0) begin
                        verr_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake, RAM port and completion outputs
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        done      = 1'b0;
        issue     = 1'b0;
        case (state_q)
            ST_IDLE: cmd_ready = 1'b1;
            ST_WR: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    mem_ce   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = cur_addr;
                    mem_data = wr_data;
`ifndef MEM_BURST_VERIFY_EN
                    done = last_beat;
`endif
                end
            end
            ST_RD: begin
                if (can_issue) begin
                    issue    = 1'b1;
                    mem_ce   = 1'b1;
                    mem_addr = cur_addr;
                end
            end
            ST_DRAIN: done = !inflight_q && (fifo_count == 2'd0);
`ifdef MEM_BURST_VERIFY_EN
            ST_VFY: begin
                if (!vissued_q) begin
                    issue    = 1'b1;
                    mem_ce   = 1'b1;
                    mem_addr = cur_addr;
                end
                done = vissued_q && !inflight_q;
            end
`endif
            default: ;
        endcase
    end

endmodule
